dso_wave_reader: RTL and testbench

- Read-side controller for the DSO sample RAM. Once per display frame it sweeps wave_rd_addr 0..HORIZONTAL-1 and converts each returned 8-bit sample into a screen (x,y) point.
- Points leave on a valid/ready stream to the waveform drawing logic.
- When the sweep completes it raises ram_rd_over, which lets the acquisition side re-arm the trigger.
- Sits entirely in the ram_rd_clk (display) domain.

---
 rtl/dso_wave_reader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_dso_wave_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dso_wave_reader.sv
`timescale 1ns/1ps
// dso_wave_reader: read-side controller for the DSO sample RAM.
// Once per display frame it sweeps wave_rd_addr 0..HORIZONTAL-1, turns each
// returned sample into a screen (x,y) point and streams the points out on a
// valid/ready interface through a small first-word-fall-through FIFO.
// When the sweep has fully drained it raises ram_rd_over until the next frame.
//
// Optional feature macro: DSO_VGAIN_EN (adds v_gain input, vertical gain with
// clamping and one extra pipeline stage ahead of the FIFO).
//
// Ports:
//   ram_rd_clk     display/read clock
//   rstn           asynchronous active-low reset
//   frame_start    one-cycle pulse at start of display frame
//   ram_rd_en      high on cycles an address is issued
//   wave_rd_addr   sample address (horizontal index)
//   wave_rd_data   sample returned RD_LAT cycles after ram_rd_en; 255 = off-screen
//   v_gain         (DSO_VGAIN_EN only) vertical gain shift 0..3
//   ram_rd_over    level, sweep of current frame finished
//   pt_valid/pt_ready  point stream handshake
//   pt_x, pt_y     screen coordinates of the point
//   pt_blank       sample was 255, draw nothing
//   pt_last        point is index HORIZONTAL-1
//   frame_overrun  sticky, frame_start arrived mid-sweep
module dso_wave_reader #(
   parameter int unsigned HORIZONTAL = 640,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned PLOT_X0    = 0,
   parameter int unsigned PLOT_Y0    = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       ram_rd_clk,
   input  logic       rstn,
   input  logic       frame_start,
   output logic       ram_rd_en,
   output logic [9:0] wave_rd_addr,
   input  logic [7:0] wave_rd_data,
`ifdef DSO_VGAIN_EN
   input  logic [1:0] v_gain,
`endif
   output logic       ram_rd_over,
   output logic       pt_valid,
   input  logic       pt_ready,
   output logic [9:0] pt_x,
   output logic [9:0] pt_y,
   output logic       pt_blank,
   output logic       pt_last,
   output logic       frame_overrun
);

   localparam int unsigned AW  = 10;
   localparam int unsigned EW  = 22;                     // {x, y, blank, last}
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned CRW = $clog2(FIFO_DEPTH + RD_LAT + 3) + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(HORIZONTAL - 1);
   localparam logic [AW-1:0] X0 = AW'(PLOT_X0);
   localparam logic [AW-1:0] Y0 = AW'(PLOT_Y0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state, state_n;

   logic          en_n;
   logic [AW-1:0] addr_n;
   logic          over_n;
   logic          overrun_n;

   // read-latency tracking: {valid, index} delayed to match the RAM
   logic [RD_LAT:1] pipe_v;
   logic [AW-1:0]   pipe_idx [1:RD_LAT];
   logic [AW-1:0]   idx_chain [0:RD_LAT];
   logic [RD_LAT:0] v_chain;

   logic          cap_v;
   logic [AW-1:0] cap_idx;
   logic [EW-1:0] cap_entry;

   logic          push_v;
   logic [EW-1:0] push_entry;

   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          pop;
   logic [EW-1:0] head;

   logic [CRW-1:0] in_flight;
   logic           credit_ok;

   // Chain views so the shift loop never indexes out of range
   always_comb begin
      v_chain      = {pipe_v, ram_rd_en};
      idx_chain[0] = wave_rd_addr;
      for (int i = 1; i <= RD_LAT; i++) begin
         idx_chain[i] = pipe_idx[i];
      end
   end

   // Delay line of issued reads
   always_ff @(posedge ram_rd_clk or negedge rstn) begin
      if (!rstn) begin
         pipe_v <= '0;
         for (int i = 1; i <= RD_LAT; i++) begin
            pipe_idx[i] <= '0;
         end
      end else begin
         for (int i = 1; i <= RD_LAT; i++) begin
            pipe_v[i]   <= v_chain[i-1];
            pipe_idx[i] <= idx_chain[i-1];
         end
      end
   end

   assign cap_v   = pipe_v[RD_LAT];
   assign cap_idx = pipe_idx[RD_LAT];

`ifdef DSO_VGAIN_EN
   // 12-bit signed so gain 3 at full deviation cannot wrap before the clamp
   logic signed [11:0] dev;
   logic signed [11:0] scaled;
   logic signed [11:0] yraw;
   logic [7:0]         yclamp;

   always_comb begin
      dev    = 12'sd127 - $signed({4'b0000, wave_rd_data});
      scaled = dev <<< v_gain;
      yraw   = 12'sd127 + scaled;
      if (yraw < 12'sd0) begin
         yclamp = 8'd0;
      end else if (yraw > 12'sd255) begin
         yclamp = 8'd255;
      end else begin
         yclamp = yraw[7:0];
      end
      cap_entry = {AW'(X0 + cap_idx), AW'(Y0 + AW'(yclamp)),
                   (wave_rd_data == 8'd255), (cap_idx == LAST_ADDR)};
   end

   // Extra register stage between capture and FIFO
   always_ff @(posedge ram_rd_clk or negedge rstn) begin
      if (!rstn) begin
         push_v     <= 1'b0;
         push_entry <= '0;
      end else begin
         push_v     <= cap_v;
         push_entry <= cap_entry;
      end
   end
`else
   always_comb begin
      cap_entry = {AW'(X0 + cap_idx), AW'(Y0 + AW'(8'd255 - wave_rd_data)),
                   (wave_rd_data == 8'd255), (cap_idx == LAST_ADDR)};
   end

   assign push_v     = cap_v;
   assign push_entry = cap_entry;
`endif

   // Reads issued but not yet in the FIFO, used for credit accounting
   always_comb begin
      in_flight = CRW'(ram_rd_en);
      for (int i = 1; i <= RD_LAT; i++) begin
         in_flight = in_flight + CRW'(pipe_v[i]);
      end
`ifdef DSO_VGAIN_EN
      in_flight = in_flight + CRW'(push_v);
`endif
   end

   assign credit_ok = (CRW'(fifo_cnt) + in_flight) < CRW'(FIFO_DEPTH);

   // Point FIFO, first-word-fall-through
   assign pt_valid = (fifo_cnt != '0);
   assign pop      = pt_valid && pt_ready;
   assign head     = fifo_mem[rd_ptr];

   always_ff @(posedge ram_rd_clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         if (push_v) begin
            fifo_mem[wr_ptr] <= push_entry;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         fifo_cnt <= fifo_cnt + CW'(push_v) - CW'(pop);
      end
   end

   // Head is gated so outputs read zero whenever no point is offered
   assign pt_x     = pt_valid ? head[21:12] : '0;
   assign pt_y     = pt_valid ? head[11:2]  : '0;
   assign pt_blank = pt_valid ? head[1]     : 1'b0;
   assign pt_last  = pt_valid ? head[0]     : 1'b0;

   // Sequencer state and registered outputs
   always_ff @(posedge ram_rd_clk or negedge rstn) begin
      if (!rstn) begin
         state         <= S_IDLE;
         ram_rd_en     <= 1'b0;
         wave_rd_addr  <= '0;
         ram_rd_over   <= 1'b0;
         frame_overrun <= 1'b0;
      end else begin
         state         <= state_n;
         ram_rd_en     <= en_n;
         wave_rd_addr  <= addr_n;
         ram_rd_over   <= over_n;
         frame_overrun <= overrun_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      addr_n    = wave_rd_addr;
      overrun_n = frame_overrun;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (frame_start) begin
               state_n = S_SWEEP;
               addr_n  = '0;
            end
         end
         S_SWEEP: begin
            if (frame_start) begin
               overrun_n = 1'b1;
            end
            if (ram_rd_en) begin
               if (wave_rd_addr == LAST_ADDR) begin
                  state_n = S_DRAIN;
               end else begin
                  addr_n = wave_rd_addr + AW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (frame_start) begin
               overrun_n = 1'b1;
            end
            if ((in_flight == '0) && (fifo_cnt == '0)) begin
               state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Issue one address per cycle while credit allows
      en_n   = (state_n == S_SWEEP) && credit_ok;
      over_n = (state_n == S_DONE);
   end

endmodule

// File: tb/tb_dso_wave_reader.sv
`timescale 1ns/1ps
module tb_dso_wave_reader;

   localparam int H   = 640;
   localparam int X0  = 400;
   localparam int Y0  = 800;

   logic       clk = 1'b0;
   logic       rstn;
   logic       frame_start;
   logic       ram_rd_en;
   logic [9:0] wave_rd_addr;
   logic [7:0] wave_rd_data;
   logic       ram_rd_over;
   logic       pt_valid;
   logic       pt_ready;
   logic [9:0] pt_x, pt_y;
   logic       pt_blank, pt_last;
   logic       frame_overrun;
`ifdef DSO_VGAIN_EN
   logic [1:0] v_gain = 2'd2;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0] ram [1024];
   logic [9:0] a_q;

   always #5 clk = ~clk;

   // RAM model: one-cycle read latency
   always @(posedge clk) a_q <= wave_rd_addr;
   assign wave_rd_data = ram[a_q];

   dso_wave_reader #(
      .HORIZONTAL(H), .RD_LAT(1), .PLOT_X0(X0), .PLOT_Y0(Y0), .FIFO_DEPTH(4)
   ) dut (
      .ram_rd_clk(clk), .rstn(rstn), .frame_start(frame_start),
      .ram_rd_en(ram_rd_en), .wave_rd_addr(wave_rd_addr), .wave_rd_data(wave_rd_data),
`ifdef DSO_VGAIN_EN
      .v_gain(v_gain),
`endif
      .ram_rd_over(ram_rd_over), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_x(pt_x), .pt_y(pt_y), .pt_blank(pt_blank), .pt_last(pt_last),
      .frame_overrun(frame_overrun)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected {over=0, x, y, blank, last} for sample index i
   function automatic logic [31:0] exp_point(input int i);
      int d, x, y;
      d = int'(ram[i]);
      x = (X0 + i) % 1024;
`ifdef DSO_VGAIN_EN
      y = 127 + ((127 - d) * (1 << 2));
      if (y < 0) y = 0;
      if (y > 255) y = 255;
      y = (Y0 + y) % 1024;
`else
      y = (Y0 + 255 - d) % 1024;
`endif
      return {9'd0, 1'b0, 10'(x), 10'(y), (d == 255), (i == H - 1)};
   endfunction

   function automatic logic [31:0] obs_point();
      return {9'd0, ram_rd_over, pt_x, pt_y, pt_blank, pt_last};
   endfunction

   task automatic run_frame(input int rdy_pct, input int ovr_at, input int rst_at);
      int exp_addr = 0;
      int pidx = 0;
      bit done = 0;
      bit ovr_done = 0;
      bit prev_stall = 0;
      bit did_rst = 0;
      logic [31:0] prev = '0;
      for (int cyc = 0; cyc < 20000 && !done && !did_rst; cyc++) begin
         @(negedge clk);
         frame_start = (cyc == 0);
         if (ovr_at >= 0 && pidx == ovr_at && !ovr_done) begin
            frame_start = 1'b1;
            ovr_done = 1;
         end
         if (rst_at >= 0 && pidx == rst_at) begin
            pt_ready = 1'b0;
            #2 rstn = 1'b0;
            #1;
            check_val("rst_outs", {ram_rd_en, wave_rd_addr, ram_rd_over, pt_valid,
                                   pt_x, pt_y, pt_blank, pt_last}, 32'd0);
            check_val("rst_overrun", 32'(frame_overrun), 32'd0);
            @(negedge clk);
            rstn = 1'b1;
            did_rst = 1;
         end else begin
            pt_ready = ($urandom_range(99) < rdy_pct);
            if (cyc == 1) check_val("over_clr", 32'(ram_rd_over), 32'd0);
            if (ram_rd_en) begin
               check_val("addr", 32'(wave_rd_addr), 32'(exp_addr));
               exp_addr++;
            end
            if (prev_stall) check_val("hold", {pt_valid, obs_point()} , {1'b1, prev});
            if (pt_valid && pt_ready) begin
               check_val("point", obs_point(), exp_point(pidx));
               pidx++;
            end
            prev_stall = pt_valid && !pt_ready;
            prev = obs_point();
            if (cyc > 1 && ram_rd_over) done = 1;
         end
      end
      frame_start = 1'b0;
      if (!did_rst) begin
         check_val("sweep_done", 32'(done), 32'd1);
         check_val("npts", 32'(pidx), 32'(H));
         check_val("naddr", 32'(exp_addr), 32'(H));
         pt_ready = 1'b1;
         repeat (6) @(negedge clk);
         check_val("after", {ram_rd_over, ram_rd_en, pt_valid, wave_rd_addr},
                   {1'b1, 1'b0, 1'b0, 10'(H - 1)});
      end
   endtask

   initial begin
      rstn = 1'b0;
      frame_start = 1'b0;
      pt_ready = 1'b0;
      for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
      repeat (3) @(negedge clk);
      check_val("reset", {ram_rd_en, wave_rd_addr, ram_rd_over, pt_valid,
                          pt_x, pt_y, pt_blank, pt_last, frame_overrun}, 32'd0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      run_frame(100, -1, -1);
      check_val("overrun0", 32'(frame_overrun), 32'd0);

      run_frame(30, -1, -1);

      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom_range(254));
      for (int i = 0; i < 10; i++) ram[i] = 8'd255;
      ram[10] = 8'd0;
      ram[H - 1] = 8'd255;
      run_frame(70, -1, -1);

      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
      run_frame(100, 300, -1);
      check_val("overrun1", 32'(frame_overrun), 32'd1);

      run_frame(50, -1, 200);

      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
      run_frame(60, -1, -1);
      check_val("overrun_post", 32'(frame_overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
